layers_readout_word_packer: RTL and testbench

- Sits directly downstream of the merged-frame byte FIFO in the layers readout path. It consumes the 8-bit AXI-Stream and feeds the host readout as 32-bit words.
- Packs four bytes into each output word and pads partial words with a configurable pad byte.
- A partial word is flushed on an input tlast, on an idle timeout, or on a software flush request.
- Keeps word and pad statistics for the register file.

---
 rtl/layers_readout_pkg.sv | 20 ++
 rtl/readout_flush_timer.sv | 67 ++++++
 rtl/layers_readout_word_packer.sv | 190 +++++++++++++++++++
 tb/tb_layers_readout_word_packer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/layers_readout_pkg.sv
// Shared types and helpers for the layers readout packers.
//
// Contents:
//   word_t          32-bit host readout word
//   keep_t          4-bit byte-lane keep mask
//   BYTES_PER_WORD  bytes packed into one word
//   byte_lane()     maps a logical byte index to its physical lane
package layers_readout_pkg;

   typedef logic [31:0] word_t;
   typedef logic [3:0]  keep_t;

   localparam int unsigned BYTES_PER_WORD = 4;

   // Logical byte 0 is the first byte to arrive on the stream.
   function automatic logic [1:0] byte_lane(input logic [1:0] idx, input bit big_endian);
      return big_endian ? (2'd3 - idx) : idx;
   endfunction

endpackage

// File: rtl/readout_flush_timer.sv
// Idle-timeout counter and flush-pending flag for a readout packer.
//
// Ports:
//   clk_core       in   core clock
//   clk_core_resn  in   synchronous active-low reset
//   timeout        in   idle cycles before a timed flush; 0 disables it
//   acc_busy       in   accumulator currently holds bytes
//   beat           in   an input byte is accepted this cycle
//   flush_req      in   explicit flush request (already qualified by the caller)
//   hold_next      in   accumulator will still hold bytes after this edge
//   flush_done     in   the padded flush word is loaded this cycle
//   pending        out  a flush is waiting for the output register
module readout_flush_timer #(
   parameter int unsigned TIMEOUT_W = 16
) (
   input  logic                 clk_core,
   input  logic                 clk_core_resn,
   input  logic [TIMEOUT_W-1:0] timeout,
   input  logic                 acc_busy,
   input  logic                 beat,
   input  logic                 flush_req,
   input  logic                 hold_next,
   input  logic                 flush_done,
   output logic                 pending
);

   logic [TIMEOUT_W-1:0] idle_q, idle_d;
   logic                 pending_q, pending_d;
   logic                 hit;

   // A timed flush fires only in a cycle with no beat, so the held bytes are
   // exactly the ones that went idle.
   assign hit = acc_busy && !beat && (timeout != '0) && (idle_q >= timeout);

   always_comb begin
      idle_d = idle_q;
      if (!acc_busy || beat) begin
         idle_d = '0;
      end else if (idle_q != '1) begin
         idle_d = idle_q + TIMEOUT_W'(1);
      end
   end

   // Setting is qualified by hold_next so a flush can never be armed for an
   // accumulator that empties on this same edge (no empty words).
   always_comb begin
      pending_d = pending_q;
      if (flush_done) begin
         pending_d = 1'b0;
      end else if ((hit || flush_req) && hold_next) begin
         pending_d = 1'b1;
      end
   end

   always_ff @(posedge clk_core) begin
      if (!clk_core_resn) begin
         idle_q    <= '0;
         pending_q <= 1'b0;
      end else begin
         idle_q    <= idle_d;
         pending_q <= pending_d;
      end
   end

   assign pending = pending_q;

endmodule

// File: rtl/layers_readout_word_packer.sv
// Packs the 8-bit merged-frame byte stream into 32-bit host readout words.
// Partial words are padded with PAD_BYTE and flushed on input tlast, on an
// idle timeout or on a software flush request.
//
// Ports:
//   clk_core, clk_core_resn     clock, synchronous active-low reset
//   s_axis_*                    8-bit input stream (tdata/tvalid/tlast/tready)
//   m_axis_*                    32-bit output stream (tdata/tkeep/tlast/tvalid/tready)
//   cfg_enable                  0 stops accepting input; output still drains
//   cfg_flush_timeout           idle cycles before a partial flush (0 = off)
//   cfg_flush                   single-cycle flush request
//   status_partial_bytes        bytes held in the accumulator
//   stat_words_out              output handshakes, wrapping
//   stat_pad_bytes              pad bytes inserted, wrapping
module layers_readout_word_packer
   import layers_readout_pkg::*;
#(
   parameter logic [7:0]  PAD_BYTE   = 8'hFF,
   parameter bit          BIG_ENDIAN = 1'b0,
   parameter int unsigned TIMEOUT_W  = 16
) (
   input  logic                 clk_core,
   input  logic                 clk_core_resn,
   input  logic [7:0]           s_axis_tdata,
   input  logic                 s_axis_tvalid,
   input  logic                 s_axis_tlast,
   output logic                 s_axis_tready,
   output logic [31:0]          m_axis_tdata,
   output logic [3:0]           m_axis_tkeep,
   output logic                 m_axis_tlast,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   input  logic                 cfg_enable,
   input  logic [TIMEOUT_W-1:0] cfg_flush_timeout,
   input  logic                 cfg_flush,
   output logic [1:0]           status_partial_bytes,
   output logic [31:0]          stat_words_out,
   output logic [31:0]          stat_pad_bytes
);

   // Accumulator: logical byte k lives in acc_q[8k +: 8].
   logic [23:0] acc_q, acc_d;
   logic [1:0]  acc_cnt_q, acc_cnt_d;

   // Output register.
   word_t       out_data_q, out_data_d;
   keep_t       out_keep_q, out_keep_d;
   logic        out_last_q, out_last_d;
   logic        out_valid_q, out_valid_d;

   logic [31:0] words_q, words_d;
   logic [31:0] pads_q, pads_d;

   logic        free;
   logic        beat;
   logic        load_beat;
   logic        load_flush;
   logic        load;
   logic        late_last;
   logic        flush_pending;
   logic        flush_req;

   word_t       word;
   keep_t       keep;
   logic [2:0]  n_bytes;

   assign free = !out_valid_q || m_axis_tready;

   // Reset term keeps every output at 0 while reset is held.
   assign s_axis_tready = clk_core_resn && cfg_enable && !((acc_cnt_q == 2'd3) && !free) &&
                          !flush_pending;

   assign beat       = s_axis_tvalid && s_axis_tready;
   assign load_beat  = beat && free && ((acc_cnt_q == 2'd3) || s_axis_tlast);
   assign load_flush = flush_pending && free;
   assign load       = load_beat || load_flush;

   // A tlast byte that arrives while the output register is stalled cannot
   // close its word on this edge. It is parked in the accumulator and a
   // pending flush (which also carries tlast=1) emits it once the register
   // frees up, so word content and framing are unchanged.
   assign late_last = beat && !free && s_axis_tlast;
   assign flush_req = (cfg_flush && (acc_cnt_q != 2'd0)) || late_last;

   readout_flush_timer #(
      .TIMEOUT_W (TIMEOUT_W)
   ) u_flush_timer (
      .clk_core      (clk_core),
      .clk_core_resn (clk_core_resn),
      .timeout       (cfg_flush_timeout),
      .acc_busy      (acc_cnt_q != 2'd0),
      .beat          (beat),
      .flush_req     (flush_req),
      .hold_next     (acc_cnt_d != 2'd0),
      .flush_done    (load_flush),
      .pending       (flush_pending)
   );

   // Word assembly: held bytes, then the current input byte unless this is a
   // flush (input is blocked during a flush), then pad. Keep is in logical
   // byte order, independent of the lane mapping.
   always_comb begin
      logic [31:0] logical;
      n_bytes = flush_pending ? {1'b0, acc_cnt_q} : ({1'b0, acc_cnt_q} + 3'd1);
      logical = {BYTES_PER_WORD{PAD_BYTE}};
      for (int k = 0; k < 3; k++) begin
         if (2'(k) < acc_cnt_q) begin
            logical[8*k +: 8] = acc_q[8*k +: 8];
         end
      end
      if (!flush_pending) begin
         logical[8*acc_cnt_q +: 8] = s_axis_tdata;
      end
      word = '0;
      keep = '0;
      for (int k = 0; k < BYTES_PER_WORD; k++) begin
         word[8*byte_lane(2'(k), BIG_ENDIAN) +: 8] = logical[8*k +: 8];
         keep[k] = (3'(k) < n_bytes);
      end
   end

   always_comb begin
      acc_d     = acc_q;
      acc_cnt_d = acc_cnt_q;
      if (load) begin
         acc_cnt_d = 2'd0;
      end else if (beat) begin
         // Without a load this beat cannot be the 4th byte, so acc_cnt_q < 3.
         acc_d[8*acc_cnt_q +: 8] = s_axis_tdata;
         acc_cnt_d = acc_cnt_q + 2'd1;
      end
   end

   always_comb begin
      out_data_d  = out_data_q;
      out_keep_d  = out_keep_q;
      out_last_d  = out_last_q;
      out_valid_d = out_valid_q;
      if (load) begin
         out_data_d  = word;
         out_keep_d  = keep;
         out_last_d  = load_flush ? 1'b1 : s_axis_tlast;
         out_valid_d = 1'b1;
      end else if (m_axis_tready) begin
         out_valid_d = 1'b0;
      end
   end

   always_comb begin
      words_d = words_q;
      pads_d  = pads_q;
      if (out_valid_q && m_axis_tready) begin
         words_d = words_q + 32'd1;
      end
      if (load && (n_bytes != 3'd4)) begin
         pads_d = pads_q + 32'(3'd4 - n_bytes);
      end
   end

   always_ff @(posedge clk_core) begin
      if (!clk_core_resn) begin
         acc_q       <= '0;
         acc_cnt_q   <= '0;
         out_data_q  <= '0;
         out_keep_q  <= '0;
         out_last_q  <= 1'b0;
         out_valid_q <= 1'b0;
         words_q     <= '0;
         pads_q      <= '0;
      end else begin
         acc_q       <= acc_d;
         acc_cnt_q   <= acc_cnt_d;
         out_data_q  <= out_data_d;
         out_keep_q  <= out_keep_d;
         out_last_q  <= out_last_d;
         out_valid_q <= out_valid_d;
         words_q     <= words_d;
         pads_q      <= pads_d;
      end
   end

   assign m_axis_tdata         = out_data_q;
   assign m_axis_tkeep         = out_keep_q;
   assign m_axis_tlast         = out_last_q;
   assign m_axis_tvalid        = out_valid_q;
   assign status_partial_bytes = acc_cnt_q;
   assign stat_words_out       = words_q;
   assign stat_pad_bytes       = pads_q;

endmodule

// File: tb/tb_layers_readout_word_packer.sv
// Self-checking bench for layers_readout_word_packer: directed scenarios for
// packing, tlast, timeout, flush, back-pressure and reset, followed by a
// randomized stream compared against a byte-grouping reference model.
module tb_layers_readout_word_packer;

   localparam bit BE = 1'b0;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  s_tdata;
   logic        s_tvalid, s_tlast, s_tready;
   logic [31:0] m_tdata;
   logic [3:0]  m_tkeep;
   logic        m_tlast, m_tvalid, m_tready;
   logic        cfg_enable, cfg_flush;
   logic [15:0] cfg_timeout;
   logic [1:0]  partial;
   logic [31:0] words_out, pad_bytes;

   int n_checks = 0;
   int n_fail   = 0;

   logic [36:0] out_q[$];   // observed {last, keep, data}
   logic [36:0] exp_q[$];   // model words
   logic [7:0]  cur_q[$];   // model bytes of the open word
   int          exp_pads = 0;
   bit          model_en = 1'b0;

   always #5 clk = ~clk;

   layers_readout_word_packer #(
      .PAD_BYTE   (8'hFF),
      .BIG_ENDIAN (BE),
      .TIMEOUT_W  (16)
   ) dut (
      .clk_core             (clk),
      .clk_core_resn        (rst_n),
      .s_axis_tdata         (s_tdata),
      .s_axis_tvalid        (s_tvalid),
      .s_axis_tlast         (s_tlast),
      .s_axis_tready        (s_tready),
      .m_axis_tdata         (m_tdata),
      .m_axis_tkeep         (m_tkeep),
      .m_axis_tlast         (m_tlast),
      .m_axis_tvalid        (m_tvalid),
      .m_axis_tready        (m_tready),
      .cfg_enable           (cfg_enable),
      .cfg_flush_timeout    (cfg_timeout),
      .cfg_flush            (cfg_flush),
      .status_partial_bytes (partial),
      .stat_words_out       (words_out),
      .stat_pad_bytes       (pad_bytes)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: bytes group into words of four; tlast closes early and
   // the rest of the word is PAD_BYTE.
   function automatic logic [36:0] model_word(input logic last);
      logic [31:0] d = 32'hFFFF_FFFF;
      logic [3:0]  k = 4'h0;
      for (int i = 0; i < cur_q.size(); i++) begin
         int lane = BE ? 3 - i : i;
         d[8*lane +: 8] = cur_q[i];
         k[i] = 1'b1;
      end
      return {last, k, d};
   endfunction

   // Sample away from the active edge: a handshake seen here happens at the next posedge.
   always @(negedge clk) begin
      if (rst_n && m_tvalid && m_tready) out_q.push_back({m_tlast, m_tkeep, m_tdata});
      if (model_en && s_tvalid && s_tready) begin
         cur_q.push_back(s_tdata);
         if (s_tlast || cur_q.size() == 4) begin
            exp_q.push_back(model_word(s_tlast));
            exp_pads += 4 - cur_q.size();
            cur_q.delete();
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic last);
      int n = 0;
      s_tdata  = d;
      s_tlast  = last;
      s_tvalid = 1'b1;
      @(negedge clk);
      while (!s_tready && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_eq("send_accept", 64'(s_tready), 64'(1));
      @(posedge clk);
      #1;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic pulse_flush();
      cfg_flush = 1'b1;
      cycles(1);
      cfg_flush = 1'b0;
   endtask

   task automatic expect_word(input string tag, input logic [31:0] d, input logic [3:0] k,
                              input logic l);
      logic [36:0] w;
      check_eq({tag, "_avail"}, 64'(out_q.size() > 0), 64'(1));
      if (out_q.size() > 0) begin
         w = out_q.pop_front();
         check_eq({tag, "_data"}, 64'(w[31:0]), 64'(d));
         check_eq({tag, "_keep"}, 64'(w[35:32]), 64'(k));
         check_eq({tag, "_last"}, 64'(w[36]), 64'(l));
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_mvalid"}, 64'(m_tvalid), 64'(0));
      check_eq({tag, "_mdata"}, 64'(m_tdata), 64'(0));
      check_eq({tag, "_mkeep"}, 64'(m_tkeep), 64'(0));
      check_eq({tag, "_mlast"}, 64'(m_tlast), 64'(0));
      check_eq({tag, "_sready"}, 64'(s_tready), 64'(0));
      check_eq({tag, "_partial"}, 64'(partial), 64'(0));
      check_eq({tag, "_words"}, 64'(words_out), 64'(0));
      check_eq({tag, "_pads"}, 64'(pad_bytes), 64'(0));
   endtask

   initial begin
      logic [7:0] stall_bytes [9];
      int idx;
      int n;
      bit acc;
      int sent;
      int cyc;
      logic [31:0] words_before, pads_before;

      rst_n = 1'b0; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
      m_tready = 1'b1; cfg_enable = 1'b1; cfg_flush = 1'b0; cfg_timeout = '0;
      cycles(3);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      cycles(1);

      // Back-to-back full words.
      for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b0);
      cycles(3);
      expect_word("full0", 32'h0403_0201, 4'hF, 1'b0);
      expect_word("full1", 32'h0807_0605, 4'hF, 1'b0);
      check_eq("full_words", 64'(words_out), 64'(2));

      // tlast-terminated partial word, one-cycle latency.
      send_byte(8'hAA, 1'b0);
      send_byte(8'hBB, 1'b0);
      send_byte(8'hCC, 1'b1);
      check_eq("tlast_latency", 64'(m_tvalid), 64'(1));
      cycles(2);
      expect_word("tlast", 32'hFFCC_BBAA, 4'b0111, 1'b1);
      check_eq("tlast_pads", 64'(pad_bytes), 64'(1));

      // Idle timeout flush.
      cfg_timeout = 16'd10;
      send_byte(8'h5A, 1'b0);
      n = 0;
      while (!m_tvalid && n < 40) begin
         cycles(1);
         n++;
      end
      check_eq("timeout_latency", 64'(n >= 11 && n <= 12), 64'(1));
      cycles(2);
      expect_word("timeout", 32'hFFFF_FF5A, 4'b0001, 1'b1);

      // Timeout disabled: the byte stays until a software flush.
      cfg_timeout = '0;
      send_byte(8'h5A, 1'b0);
      cycles(50);
      check_eq("no_timeout_words", 64'(out_q.size()), 64'(0));
      check_eq("no_timeout_partial", 64'(partial), 64'(1));
      pulse_flush();
      cycles(3);
      expect_word("sw_flush", 32'hFFFF_FF5A, 4'b0001, 1'b1);

      // Flush with an empty accumulator emits nothing.
      pulse_flush();
      cycles(5);
      check_eq("empty_flush_words", 64'(out_q.size()), 64'(0));

      // Back-pressure: 9 bytes against a stalled output.
      for (int i = 0; i < 9; i++) stall_bytes[i] = 8'h11 + 8'(i);
      m_tready = 1'b0;
      idx = 0;
      for (int c = 0; c < 20; c++) begin
         s_tvalid = (idx < 9);
         s_tdata  = stall_bytes[idx < 9 ? idx : 8];
         @(negedge clk);
         acc = s_tvalid && s_tready;
         cycles(1);
         if (acc) idx++;
      end
      check_eq("stall_accepted", 64'(idx), 64'(7));
      check_eq("stall_sready", 64'(s_tready), 64'(0));
      check_eq("stall_mvalid", 64'(m_tvalid), 64'(1));
      check_eq("stall_mdata", 64'(m_tdata), 64'(32'h1413_1211));
      m_tready = 1'b1;
      n = 0;
      while (idx < 9 && n < 30) begin
         s_tvalid = 1'b1;
         s_tdata  = stall_bytes[idx];
         @(negedge clk);
         acc = s_tvalid && s_tready;
         cycles(1);
         if (acc) idx++;
         n++;
      end
      s_tvalid = 1'b0;
      check_eq("stall_resumed", 64'(idx), 64'(9));
      cycles(3);
      expect_word("stall0", 32'h1413_1211, 4'hF, 1'b0);
      expect_word("stall1", 32'h1817_1615, 4'hF, 1'b0);
      check_eq("stall_partial", 64'(partial), 64'(1));
      pulse_flush();
      cycles(3);
      expect_word("stall_flush", 32'hFFFF_FF19, 4'b0001, 1'b1);

      // Flush requested while the output register is stalled.
      m_tready = 1'b0;
      for (int i = 0; i < 6; i++) send_byte(8'h21 + 8'(i), 1'b0);
      check_eq("held_partial", 64'(partial), 64'(2));
      pulse_flush();
      cycles(5);
      check_eq("held_mvalid", 64'(m_tvalid), 64'(1));
      check_eq("held_mdata", 64'(m_tdata), 64'(32'h2423_2221));
      check_eq("held_sready", 64'(s_tready), 64'(0));
      m_tready = 1'b1;
      cycles(4);
      expect_word("held0", 32'h2423_2221, 4'hF, 1'b0);
      expect_word("held1", 32'hFFFF_2625, 4'b0011, 1'b1);
      check_eq("stats_words", 64'(words_out), 64'(10));
      check_eq("stats_pads", 64'(pad_bytes), 64'(12));

      // Reset with two bytes held.
      send_byte(8'h31, 1'b0);
      send_byte(8'h32, 1'b0);
      rst_n = 1'b0;
      cycles(3);
      check_reset_outputs("midreset");
      rst_n = 1'b1;
      cycles(20);
      check_eq("midreset_words", 64'(out_q.size()), 64'(0));
      for (int i = 0; i < 4; i++) send_byte(8'h41 + 8'(i), 1'b0);
      cycles(3);
      expect_word("post_reset", 32'h4443_4241, 4'hF, 1'b0);
      check_eq("post_reset_words", 64'(words_out), 64'(1));

      // Randomized stream with random back-pressure against the model.
      words_before = words_out;
      pads_before  = pad_bytes;
      out_q.delete();
      model_en = 1'b1;
      sent = 0;
      cyc  = 0;
      while (sent < 300 && cyc < 5000) begin
         if (!s_tvalid && $urandom_range(0, 3) != 0) begin
            s_tdata  = 8'($urandom);
            s_tlast  = ($urandom_range(0, 7) == 0) || (sent == 299);
            s_tvalid = 1'b1;
         end
         m_tready = ($urandom_range(0, 2) != 0);
         @(negedge clk);
         acc = s_tvalid && s_tready;
         cycles(1);
         if (acc) begin
            sent++;
            s_tvalid = 1'b0;
            s_tlast  = 1'b0;
         end
         cyc++;
      end
      m_tready = 1'b1;
      cycles(20);
      model_en = 1'b0;
      check_eq("rand_sent", 64'(sent), 64'(300));
      check_eq("rand_count", 64'(out_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
         check_eq($sformatf("rand_word%0d", i), 64'(out_q[i]), 64'(exp_q[i]));
      end
      check_eq("rand_stat_words", 64'(words_out - words_before), 64'(exp_q.size()));
      check_eq("rand_stat_pads", 64'(pad_bytes - pads_before), 64'(exp_pads));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
